npc_seq_ctrl: RTL and testbench
===============================

// Module: npc_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the npc core: owns the PC, fetches each instruction over a valid/ready
//  memory port and presents it to the decoder. Strobes the ALU for one cycle, then the register-file
//  write, then advances the PC using the next-PC value from the datapath.
//  Halts on ebreak, fetch timeout or misaligned next PC.
// PARAMETERS
//  RESET_PC       32'h8000_0000  PC value loaded on reset
//  FETCH_TIMEOUT  255            max cycles spent in FETCH+WAIT for one instruction before error halt (1..255)
// PORTS
//  clk             in   1   clock, all state updates on rising edge
//  rst_n           in   1   asynchronous active-low reset
//  start           in   1   leave IDLE and begin fetching at pc
//  imem_req_valid  out  1   fetch request valid
//  imem_req_ready  in   1   memory accepts request
//  imem_req_addr   out  32  fetch address (== pc)
//  imem_rsp_valid  in   1   fetch data valid
//  imem_rsp_data   in   32  fetched instruction word
//  inst            out  32  latched instruction to decoder
//  alu_en          out  1   one-cycle ALU evaluate strobe
//  rd              in   5   destination register from decoder
//  rf_wen          out  1   one-cycle register-file write enable
//  pc_next         in   32  next PC computed by datapath (pc+4 or target)
//  pc              out  32  current PC
//  halt            out  1   core halted (sticky until reset)
//  err             out  2   0 none, 1 fetch timeout, 2 misaligned pc_next (sticky)
//  mcycle          out  64  cycle counter (optional, see CONFIGURATION)
//  minstret        out  64  retired-instruction counter (optional)
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, pc=RESET_PC, inst=32'h0000_0013 (nop), imem_req_valid=0, alu_en=0, rf_wen=0,
//   halt=0, err=0, timer=0, mcycle=0, minstret=0. Asserting rst_n low mid-operation aborts any fetch in flight.
//   A response arriving after reset release is dropped because the state is IDLE.
//  States: IDLE -> FETCH -> WAIT -> EXEC -> WB -> FETCH ...; HALT is terminal.
//  IDLE:  outputs idle; start=1 -> FETCH next cycle. start is ignored in all other states.
//  FETCH: imem_req_valid=1 and imem_req_addr=pc, held stable until imem_req_ready.
//   Handshake (valid&ready) -> WAIT. imem_rsp_valid in FETCH is ignored.
//  WAIT:  the first cycle with imem_rsp_valid=1 latches inst<=imem_rsp_data -> EXEC. Earliest rsp is the cycle after the handshake.
//  Timer: cleared on entry to FETCH; increments each cycle in FETCH or WAIT.
//   Reaching FETCH_TIMEOUT without a latched response -> HALT, err=1, imem_req_valid dropped.
//  EXEC:  alu_en=1 for exactly this cycle.
//   inst==32'h0010_0073 (ebreak) -> HALT, err=0, no rf_wen, pc not updated, minstret +1. Otherwise -> WB.
//  WB:    rf_wen = (rd!=5'd0) for this cycle only. pc_next[1:0]!=0 -> HALT, err=2, pc unchanged, minstret unchanged.
//   Otherwise pc<=pc_next, minstret +1 -> FETCH.
//  HALT:  halt=1; all strobes and req_valid are 0; pc, inst and err are frozen until reset.
//  Throughput: 4 cycles/instruction with a zero-wait memory (ready=1, rsp one cycle after request).
//  alu_en and rf_wen are never high in the same cycle. Both are registered outputs (no comb path from inputs).
//  Counter arithmetic: 64-bit unsigned, wraps modulo 2^64. mcycle increments every cycle outside IDLE and HALT.
// CONFIGURATION
//  NPC_PERF_CNT_EN defined: mcycle/minstret implemented as described.
//  NPC_PERF_CNT_EN undefined: counter logic is removed and mcycle/minstret are driven constant 64'd0. Ports are unchanged.
// STRUCTURE
//  npc_pkg (shared): state enum {IDLE,FETCH,WAIT,EXEC,WB,HALT}, INST_NOP, INST_EBREAK, err codes
//   (ERR_NONE, ERR_TIMEOUT, ERR_MISALIGN).
//  Sub-module npc_perf_cnt: the two 64-bit counters with inc inputs. Instantiated only under NPC_PERF_CNT_EN.
//  FSM, PC register and timer live in this module.
// TESTING
//  1. Reset, start=1, zero-wait memory returning 32'h00A0_0113 with pc_next=pc+4
//     -> req addrs 8000_0000, 8000_0004, ... every 4 cycles; alu_en and rf_wen pulse once each per instruction.
//  2. imem_req_ready held low 3 cycles -> req_valid and addr stay stable; handshake on 4th cycle; no early inst latch.
//  3. Memory never responds, FETCH_TIMEOUT=8 -> HALT after 8 cycles, err=1, halt=1, req_valid=0, pc unchanged.
//  4. Fetch returns 32'h0010_0073 -> one alu_en pulse, no rf_wen, then halt=1, err=0.
//     With NPC_PERF_CNT_EN, minstret increments by 1.
//  5. Instruction with rd=0, then pc_next=8000_0006 -> rf_wen stays 0; next WB causes HALT with err=2, pc=previous value.
//  6. rst_n low during WAIT, then response arrives after release -> outputs at reset values, state IDLE,
//     response ignored; start restarts at RESET_PC.

Source files
------------

// File: rtl/npc_pkg.sv
// npc_pkg: shared sequencer state encoding, instruction constants and error codes
package npc_pkg;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EXEC, WB, HALT} state_t;
  typedef enum logic [1:0] {ERR_NONE = 2'd0, ERR_TIMEOUT = 2'd1, ERR_MISALIGN = 2'd2} err_t;
  localparam logic [31:0] INST_NOP    = 32'h0000_0013;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
endpackage

// File: rtl/npc_perf_cnt.sv
// npc_perf_cnt: 64-bit mcycle/minstret counters, wrapping modulo 2^64
// Ports: clk, rst_n (async low); i_cyc_inc/i_ret_inc increment strobes; o_mcycle/o_minstret counts.
module npc_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cyc_inc,
  input  logic        i_ret_inc,
  output logic [63:0] o_mcycle,
  output logic [63:0] o_minstret
);
  logic [63:0] r_mcycle, r_minstret;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
    end else begin
      r_mcycle   <= i_cyc_inc ? r_mcycle + 64'd1 : r_mcycle;
      r_minstret <= i_ret_inc ? r_minstret + 64'd1 : r_minstret;
    end
  end
  assign o_mcycle   = r_mcycle;
  assign o_minstret = r_minstret;
endmodule

// File: rtl/npc_seq_ctrl.sv
// npc_seq_ctrl: multi-cycle fetch/exec/writeback sequencer owning the PC
// Ports: clk, rst_n (async low), start; imem request (valid/ready/addr) and response (valid/data);
//   inst to decoder, alu_en/rf_wen strobes, rd and pc_next from datapath; pc, halt, err, mcycle, minstret.
// NPC_PERF_CNT_EN defined: mcycle/minstret counters built; otherwise both tie to zero.
module npc_seq_ctrl
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_PC      = 32'h8000_0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] inst,
  output logic        alu_en,
  input  logic [4:0]  rd,
  output logic        rf_wen,
  input  logic [31:0] pc_next,
  output logic [31:0] pc,
  output logic        halt,
  output logic [1:0]  err,
  output logic [63:0] mcycle,
  output logic [63:0] minstret
);
  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_inst;
  logic [7:0]  r_timer;
  err_t        r_err;
  logic        r_alu_en, r_rf_wen;
  logic        w_tmo, w_fetching, w_to_halt;
  assign w_tmo      = r_timer == 8'(FETCH_TIMEOUT - 1);
  assign w_fetching = r_state == FETCH || r_state == WAIT;
  assign w_to_halt  = w_state_nxt == HALT && r_state != HALT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end
  // a response latched on the final allowed cycle wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    w_state_nxt = start ? FETCH : IDLE;
      FETCH:   w_state_nxt = w_tmo ? HALT : imem_req_ready ? WAIT : FETCH;
      WAIT:    w_state_nxt = imem_rsp_valid ? EXEC : w_tmo ? HALT : WAIT;
      EXEC:    w_state_nxt = r_inst == INST_EBREAK ? HALT : WB;
      WB:      w_state_nxt = pc_next[1:0] != 2'b00 ? HALT : FETCH;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    imem_req_valid = r_state == FETCH;
    halt           = r_state == HALT;
  end
  // timer restarts from zero on every FETCH entry because the preceding state is never FETCH/WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_inst   <= INST_NOP;
      r_timer  <= '0;
      r_err    <= ERR_NONE;
      r_alu_en <= 1'b0;
      r_rf_wen <= 1'b0;
    end else begin
      r_pc     <= r_state == WB && w_state_nxt == FETCH ? pc_next : r_pc;
      r_inst   <= r_state == WAIT && imem_rsp_valid ? imem_rsp_data : r_inst;
      r_timer  <= w_fetching ? r_timer + 8'd1 : '0;
      r_err    <= w_to_halt && w_fetching ? ERR_TIMEOUT : w_to_halt && r_state == WB ? ERR_MISALIGN : r_err;
      r_alu_en <= w_state_nxt == EXEC;
      r_rf_wen <= r_state == EXEC && w_state_nxt == WB && rd != 5'd0;
    end
  end
  assign imem_req_addr = r_pc;
  assign pc            = r_pc;
  assign inst          = r_inst;
  assign err           = r_err;
  assign alu_en        = r_alu_en;
  assign rf_wen        = r_rf_wen;
`ifdef NPC_PERF_CNT_EN
  logic w_cyc_inc, w_ret_inc;
  assign w_cyc_inc = r_state != IDLE && r_state != HALT;
  assign w_ret_inc = (r_state == EXEC && r_inst == INST_EBREAK) || (r_state == WB && w_state_nxt == FETCH);
  npc_perf_cnt u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cyc_inc  (w_cyc_inc),
    .i_ret_inc  (w_ret_inc),
    .o_mcycle   (mcycle),
    .o_minstret (minstret)
  );
`else
  assign mcycle   = '0;
  assign minstret = '0;
`endif
endmodule

// File: tb/tb_npc_seq_ctrl.sv
// tb_npc_seq_ctrl: directed plus randomized checks of npc_seq_ctrl against a per-instruction model
module tb_npc_seq_ctrl;
  import npc_pkg::*;
  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam int          TMO = 8;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, inst, pc, pc_next = '0;
  logic        alu_en, rf_wen, halt;
  logic [4:0]  rd = '0;
  logic [1:0]  err;
  logic [63:0] mcycle, minstret;
  int          errs = 0, checks = 0;
  logic [31:0] m_pc, m_inst;
  logic [63:0] m_cyc, m_ret;
  npc_seq_ctrl #(.RESET_PC(RPC), .FETCH_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst(inst), .alu_en(alu_en), .rd(rd), .rf_wen(rf_wen), .pc_next(pc_next),
    .pc(pc), .halt(halt), .err(err), .mcycle(mcycle), .minstret(minstret)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_perf(input string tag);
`ifdef NPC_PERF_CNT_EN
    chk({tag, ".mcycle"}, mcycle, m_cyc);
    chk({tag, ".minstret"}, minstret, m_ret);
`else
    chk({tag, ".mcycle"}, mcycle, 64'd0);
    chk({tag, ".minstret"}, minstret, 64'd0);
`endif
  endtask
  task automatic chk_quiet(input string tag, input logic exp_halt, input logic [1:0] exp_err);
    chk({tag, ".halt"}, halt, exp_halt);
    chk({tag, ".err"}, err, exp_err);
    chk({tag, ".req_valid"}, imem_req_valid, 0);
    chk({tag, ".alu_en"}, alu_en, 0);
    chk({tag, ".rf_wen"}, rf_wen, 0);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".inst"}, inst, m_inst);
    chk_perf(tag);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    m_pc = RPC;
    m_inst = INST_NOP;
    m_cyc = 0;
    m_ret = 0;
    #1;
    chk_quiet("reset", 0, ERR_NONE);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic hold_idle(input int n);
    for (int i = 0; i < n; i++) begin
      chk_quiet("idle", 0, ERR_NONE);
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data = $urandom;
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;
  endtask
  task automatic hold_halt(input int n, input logic [1:0] exp_err);
    for (int i = 0; i < n; i++) begin
      chk_quiet("halted", 1, exp_err);
      start = 1'($urandom_range(0, 1));
      imem_req_ready = 1'($urandom_range(0, 1));
      imem_rsp_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
  endtask
  task automatic go();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  // one instruction: rw stall cycles before the handshake, sw cycles before the response
  task automatic run_instr(input int rw, input int sw, input logic [31:0] word, input logic [4:0] rdv, input logic [31:0] pcn);
    chk("fetch.pc", pc, m_pc);
    chk("fetch.halt", halt, 0);
    chk_perf("fetch");
    for (int i = 0; i <= rw; i++) begin
      chk("fetch.req_valid", imem_req_valid, 1);
      chk("fetch.addr", imem_req_addr, m_pc);
      chk("fetch.alu_en", alu_en, 0);
      chk("fetch.rf_wen", rf_wen, 0);
      chk("fetch.inst", inst, m_inst);
      imem_req_ready = i == rw;
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data = $urandom;
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    for (int j = 0; j <= sw; j++) begin
      chk("wait.req_valid", imem_req_valid, 0);
      chk("wait.alu_en", alu_en, 0);
      chk("wait.inst", inst, m_inst);
      imem_rsp_valid = j == sw;
      imem_rsp_data = j == sw ? word : $urandom;
      @(negedge clk);
    end
    imem_rsp_valid = 1'b0;
    m_inst = word;
    chk("exec.alu_en", alu_en, 1);
    chk("exec.rf_wen", rf_wen, 0);
    chk("exec.inst", inst, word);
    chk("exec.req_valid", imem_req_valid, 0);
    rd = rdv;
    pc_next = pcn;
    @(negedge clk);
    m_cyc += 64'(rw + sw + 3);
    if (word == INST_EBREAK) begin
      m_ret++;
      chk_quiet("ebreak", 1, ERR_NONE);
      return;
    end
    chk("wb.rf_wen", rf_wen, rdv != 5'd0);
    chk("wb.alu_en", alu_en, 0);
    chk("wb.halt", halt, 0);
    @(negedge clk);
    m_cyc++;
    if (pcn[1:0] != 2'b00) begin
      chk_quiet("misalign", 1, ERR_MISALIGN);
      return;
    end
    m_pc = pcn;
    m_ret++;
  endtask
  initial begin
    logic [31:0] w, p;
    do_reset();
    hold_idle(3);
    go();
    for (int k = 0; k < 3; k++) run_instr(0, 0, 32'h00A0_0113, 5'd2, m_pc + 32'd4);
    run_instr(3, 0, 32'h00A0_0113, 5'd2, m_pc + 32'd4);
    for (int k = 0; k < 6; k++) begin
      w = $urandom;
      if (w == INST_EBREAK) w = INST_NOP;
      p = $urandom_range(0, 1) ? m_pc + 32'd4 : ($urandom & ~32'h3);
      run_instr($urandom_range(0, 2), $urandom_range(0, 2), w, 5'($urandom), p);
    end
    run_instr(0, 0, 32'h0000_0033, 5'd0, m_pc + 32'd4);
    run_instr(1, 1, 32'h00A0_0113, 5'd3, m_pc + 32'd6);
    hold_halt(4, ERR_MISALIGN);
    do_reset();
    go();
    run_instr($urandom_range(0, 2), $urandom_range(0, 2), 32'h00A0_0113, 5'd7, m_pc + 32'd4);
    run_instr(0, 1, INST_EBREAK, 5'd1, m_pc + 32'd4);
    hold_halt(3, ERR_NONE);
    do_reset();
    go();
    for (int i = 0; i < TMO; i++) begin
      chk("tmo.halt", halt, 0);
      chk("tmo.req_valid", imem_req_valid, i < 3);
      imem_req_ready = i == 2;
      imem_rsp_valid = i < 3 ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    m_cyc += 64'(TMO);
    hold_halt(3, ERR_TIMEOUT);
    do_reset();
    go();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    @(negedge clk);
    do_reset();
    imem_rsp_valid = 1'b1;
    imem_rsp_data = INST_EBREAK;
    @(negedge clk);
    hold_idle(2);
    go();
    run_instr(0, 0, 32'h00A0_0113, 5'd2, RPC + 32'd4);
    chk("restart.pc", pc, RPC + 32'd4);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
